// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic number generator bank.
// LFSR tap masks use bit (W-1-e) for each polynomial term x^e with 0 < e < W, plus bit W-1.
package sc_pkg;

    localparam int MAX_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sc_state_t;

    function automatic logic [MAX_W-1:0] lfsr_taps(input int w);
        case (w)
            4:       return 12'h009;
            5:       return 12'h012;
            6:       return 12'h021;
            7:       return 12'h041;
            8:       return 12'h08E;
            9:       return 12'h108;
            10:      return 12'h204;
            11:      return 12'h402;
            12:      return 12'hCA0;
            default: return 12'h08E;
        endcase
    endfunction

    // Rotate the low w bits of v left by amt; bits above w are cleared.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v, input int amt, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < w) begin
                r[b] = v[4'((b - (amt % w) + w) % w)];
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < w) begin
                r[b] = v[4'((w - 1 - b + MAX_W) % MAX_W)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci maximal-length LFSR; reset or load returns it to SEED, en steps it once.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int            W    = 8,
    parameter logic [W-1:0]  SEED = W'(1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[W-2:0], ^(state & TAPS)};
        end
    end

endmodule

// File: rtl/sc_sng_bank.sv
// Bank of N stochastic number generators producing one full LFSR period of
// unipolar activation and weight bitstreams per start request.
module sc_sng_bank
    import sc_pkg::*;
#(
    parameter int           K      = 3,
    parameter int           N      = 2**K,
    parameter int           W      = 8,
    parameter logic [W-1:0] SEED_X = W'(1),
    parameter logic [W-1:0] SEED_W = W'(8'hA5)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [N*W-1:0] x_val,
    input  logic [N*W-1:0] w_val,
    output logic [N-1:0]   din,
    output logic [N-1:0]   weight,
    output logic           bit_valid,
    output logic           busy,
    output logic           done
);

    localparam logic [W-1:0] LAST = W'((1 << W) - 2);

    sc_state_t             state;
    logic [W-1:0]          count;
    logic                  completed;
    logic [N-1:0][W-1:0]   x_lane;
    logic [N-1:0][W-1:0]   w_lane;
    logic [W-1:0]          lfsr_x;
    logic [W-1:0]          lfsr_w;
    logic [N-1:0]          cmp_x;
    logic [N-1:0]          cmp_w;
    logic                  lfsr_load;
    logic                  lfsr_en;

    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_en   = (state == RUN);

    sc_lfsr #(.W(W), .SEED(SEED_X)) u_lfsr_x (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .state (lfsr_x)
    );

    sc_lfsr #(.W(W), .SEED(SEED_W)) u_lfsr_w (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .state (lfsr_w)
    );

    // Each lane sees its own rotation of the shared LFSRs; the weight side is
    // also bit-reversed so it does not track the activation stream.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign cmp_x[i] = W'(rotl(MAX_W'(lfsr_x), i, W)) <= x_lane[i];
        assign cmp_w[i] = W'(bitrev(rotl(MAX_W'(lfsr_w), i, W), W)) <= w_lane[i];
    end

    // A window ends on the last count even if abort arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            completed <= 1'b0;
            x_lane    <= '0;
            w_lane    <= '0;
            din       <= '0;
            weight    <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            din       <= '0;
            weight    <= '0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= '0;
                        x_lane <= x_val;
                        w_lane <= w_val;
                    end
                end
                RUN: begin
                    din       <= cmp_x;
                    weight    <= cmp_w;
                    bit_valid <= 1'b1;
                    count     <= count + W'(1);
                    if (count == LAST) begin
                        state     <= DRAIN;
                        completed <= 1'b1;
                    end else if (abort) begin
                        state     <= DRAIN;
                        completed <= 1'b0;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= completed;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_sng_bank.sv
// Directed self-checking bench for sc_sng_bank at K=3, W=8.
module tb_sc_sng_bank;

    localparam int K = 3;
    localparam int N = 8;
    localparam int W = 8;
    localparam int L = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [N*W-1:0] x_val;
    logic [N*W-1:0] w_val;
    logic [N-1:0]   din;
    logic [N-1:0]   weight;
    logic           bit_valid;
    logic           busy;
    logic           done;

    sc_sng_bank #(.K(K), .N(N), .W(W), .SEED_X(8'h01), .SEED_W(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .x_val     (x_val),
        .w_val     (w_val),
        .din       (din),
        .weight    (weight),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int n_valid, n_done, first_valid_cyc, last_valid_cyc, done_cyc;
    int idle_cyc, abort_cyc, zero_viol, busy_first;
    bit timed_out;
    int cnt_x [N];
    int cnt_w [N];
    int cnt_and [N];
    logic [N-1:0] rec_x [L];
    logic [N-1:0] rec_w [L];
    logic [N-1:0] ref_x [L];
    logic [N-1:0] ref_w [L];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int i);
        logic [15:0] t;
        t = {v, v} << i;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    task set_start(input logic [W-1:0] xv, input logic [W-1:0] wv);
        x_val = {N{xv}};
        w_val = {N{wv}};
        start = 1'b1;
    endtask

    // Records one window starting the cycle after start is sampled; cycle 1 is
    // the first cycle after that edge. Stops at done, or 3 cycles after busy falls.
    task capture(input int abort_at, input int reset_at, input int poke_at, input int max_cycles);
        n_valid = 0; n_done = 0; first_valid_cyc = -1; last_valid_cyc = -1;
        done_cyc = -1; idle_cyc = -1; abort_cyc = -1; zero_viol = 0;
        busy_first = -1; timed_out = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt_x[i] = 0; cnt_w[i] = 0; cnt_and[i] = 0;
        end
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            reset = 1'b0;
            if (cyc == 3) begin
                x_val = ~x_val;
                w_val = ~w_val;
            end
            if (cyc == 1) busy_first = int'(busy);
            if (!bit_valid && (din != '0 || weight != '0)) zero_viol++;
            if (bit_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
                if (n_valid < L) begin
                    rec_x[n_valid] = din;
                    rec_w[n_valid] = weight;
                end
                for (int i = 0; i < N; i++) begin
                    cnt_x[i]   += int'(din[i]);
                    cnt_w[i]   += int'(weight[i]);
                    cnt_and[i] += int'(din[i] & weight[i]);
                end
                n_valid++;
                if (n_valid == abort_at) begin
                    abort = 1'b1;
                    abort_cyc = cyc;
                end
                if (n_valid == reset_at) reset = 1'b1;
                if (poke_at > 0 && (n_valid == poke_at || n_valid == L)) start = 1'b1;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!busy && cyc > 1 && idle_cyc < 0) idle_cyc = cyc;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (idle_cyc > 0 && cyc >= idle_cyc + 3) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; x_val = '0; w_val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", bit_valid); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if ({din, weight} !== 16'h0) begin failures++; $display("[TB] FAIL reset_streams: got %h expected 0000", {din, weight}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_start: busy got %b expected 0", busy); end
    endtask

    task test_full_scale;
        int bad;
        @(negedge clk);
        set_start(8'h00, 8'hFF);
        capture(0, 0, 0, 400);
        checks++;
        if (busy_first !== 1) begin failures++; $display("[TB] FAIL full_busy_t1: got %0d expected 1", busy_first); end
        checks++;
        if (first_valid_cyc !== 2) begin failures++; $display("[TB] FAIL full_first_valid: got %0d expected 2", first_valid_cyc); end
        checks++;
        if (n_valid !== L) begin failures++; $display("[TB] FAIL full_len: got %0d expected %0d", n_valid, L); end
        checks++;
        if (last_valid_cyc !== L + 1) begin failures++; $display("[TB] FAIL full_last_valid: got %0d expected %0d", last_valid_cyc, L + 1); end
        checks++;
        if (n_done !== 1 || done_cyc !== L + 2) begin
            failures++; $display("[TB] FAIL full_done: got count %0d at %0d expected 1 at %0d", n_done, done_cyc, L + 2);
        end
        bad = -1;
        for (int i = 0; i < N; i++) if (cnt_x[i] !== 0 && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin failures++; $display("[TB] FAIL full_din_ones: lane %0d got %0d expected 0", bad, cnt_x[bad]); end
        bad = -1;
        for (int i = 0; i < N; i++) if (cnt_w[i] !== L && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin failures++; $display("[TB] FAIL full_weight_ones: lane %0d got %0d expected %0d", bad, cnt_w[bad], L); end
        checks++;
        if (zero_viol !== 0) begin failures++; $display("[TB] FAIL full_idle_zero: got %0d nonzero idle cycles expected 0", zero_viol); end
    endtask

    task test_half;
        int bad, mm, and_bad;
        int exp_and [N];
        logic [7:0] sx, sw;
        logic ex, ew;
        @(negedge clk);
        set_start(8'd128, 8'd64);
        capture(0, 0, 0, 400);
        checks++;
        if (n_valid !== L || n_done !== 1) begin
            failures++; $display("[TB] FAIL half_window: got len %0d done %0d expected %0d and 1", n_valid, n_done, L);
        end
        bad = -1;
        for (int i = 0; i < N; i++) if ((cnt_x[i] !== 128 || cnt_w[i] !== 64) && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("[TB] FAIL half_counts: lane %0d got %0d/%0d expected 128/64", bad, cnt_x[bad], cnt_w[bad]);
        end
        sx = 8'h01; sw = 8'hA5; mm = 0;
        for (int i = 0; i < N; i++) exp_and[i] = 0;
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < N; i++) begin
                ex = rotl8(sx, i) <= 8'd128;
                ew = rev8(rotl8(sw, i)) <= 8'd64;
                if (rec_x[k][i] !== ex || rec_w[k][i] !== ew) mm++;
                exp_and[i] += int'(ex & ew);
            end
            sx = {sx[6:0], sx[7] ^ sx[3] ^ sx[2] ^ sx[1]};
            sw = {sw[6:0], sw[7] ^ sw[3] ^ sw[2] ^ sw[1]};
        end
        checks++;
        if (mm !== 0) begin failures++; $display("[TB] FAIL half_stream_model: got %0d differing bits expected 0", mm); end
        and_bad = -1;
        for (int i = 0; i < N; i++) if (cnt_and[i] !== exp_and[i] && and_bad < 0) and_bad = i;
        checks++;
        if (and_bad >= 0) begin
            failures++; $display("[TB] FAIL half_and_model: lane %0d got %0d expected %0d", and_bad, cnt_and[and_bad], exp_and[and_bad]);
        end
        and_bad = -1;
        for (int i = 0; i < N; i++) if ((cnt_and[i] < 16 || cnt_and[i] > 48) && and_bad < 0) and_bad = i;
        checks++;
        if (and_bad >= 0) begin
            failures++; $display("[TB] FAIL half_and_range: lane %0d got %0d expected 16..48", and_bad, cnt_and[and_bad]);
        end
        for (int k = 0; k < L; k++) begin
            ref_x[k] = rec_x[k];
            ref_w[k] = rec_w[k];
        end
    endtask

    task test_start_ignored;
        int bad;
        logic [W-1:0] xv, wv;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            xv = 8'(10 * i + 3);
            wv = 8'(200 - 7 * i);
            x_val[i*W +: W] = xv;
            w_val[i*W +: W] = wv;
        end
        start = 1'b1;
        capture(0, 0, 100, 400);
        checks++;
        if (n_valid !== L) begin failures++; $display("[TB] FAIL ignore_len: got %0d expected %0d", n_valid, L); end
        checks++;
        if (n_done !== 1) begin failures++; $display("[TB] FAIL ignore_done: got %0d expected 1", n_done); end
        bad = -1;
        for (int i = 0; i < N; i++) if ((cnt_x[i] !== 10 * i + 3 || cnt_w[i] !== 200 - 7 * i) && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("[TB] FAIL ignore_lane_counts: lane %0d got %0d/%0d expected %0d/%0d",
                                 bad, cnt_x[bad], cnt_w[bad], 10 * bad + 3, 200 - 7 * bad);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL ignore_restart: busy/valid got %b%b expected 00", busy, bit_valid);
        end
    endtask

    task test_abort;
        @(negedge clk);
        set_start(8'd128, 8'd64);
        capture(100, 0, 0, 400);
        checks++;
        if (n_valid < 100 || n_valid > 101) begin failures++; $display("[TB] FAIL abort_len: got %0d expected 100..101", n_valid); end
        checks++;
        if (n_done !== 0) begin failures++; $display("[TB] FAIL abort_done: got %0d expected 0", n_done); end
        checks++;
        if (timed_out || idle_cyc < 0 || idle_cyc > abort_cyc + 2) begin
            failures++; $display("[TB] FAIL abort_busy_drop: got idle at %0d expected by %0d", idle_cyc, abort_cyc + 2);
        end
        checks++;
        if (zero_viol !== 0) begin failures++; $display("[TB] FAIL abort_idle_zero: got %0d expected 0", zero_viol); end
    endtask

    task test_reset_mid;
        int mm;
        @(negedge clk);
        set_start(8'd128, 8'd64);
        capture(0, 50, 0, 400);
        checks++;
        if (n_done !== 0 || n_valid !== 50) begin
            failures++; $display("[TB] FAIL resetmid_first: got len %0d done %0d expected 50 and 0", n_valid, n_done);
        end
        @(negedge clk);
        set_start(8'd128, 8'd64);
        capture(0, 0, 0, 400);
        mm = 0;
        for (int k = 0; k < L; k++) if (rec_x[k] !== ref_x[k] || rec_w[k] !== ref_w[k]) mm++;
        checks++;
        if (n_done !== 1 || n_valid !== L || mm !== 0) begin
            failures++; $display("[TB] FAIL resetmid_second: got len %0d done %0d diffs %0d expected %0d 1 0", n_valid, n_done, mm, L);
        end
    endtask

    task test_back_to_back;
        int mm;
        @(negedge clk);
        set_start(8'd128, 8'd64);
        capture(0, 0, 0, 400);
        checks++;
        if (n_done !== 1) begin failures++; $display("[TB] FAIL b2b_first_done: got %0d expected 1", n_done); end
        set_start(8'd128, 8'd64);
        capture(0, 0, 0, 400);
        checks++;
        if (first_valid_cyc !== 2) begin failures++; $display("[TB] FAIL b2b_first_valid: got %0d expected 2", first_valid_cyc); end
        mm = 0;
        for (int k = 0; k < L; k++) if (rec_x[k] !== ref_x[k] || rec_w[k] !== ref_w[k]) mm++;
        checks++;
        if (n_done !== 1 || n_valid !== L || mm !== 0) begin
            failures++; $display("[TB] FAIL b2b_second: got len %0d done %0d diffs %0d expected %0d 1 0", n_valid, n_done, mm, L);
        end
    endtask

    initial begin
        test_reset;
        test_full_scale;
        test_half;
        test_start_ignored;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
